pred_ctx_seq: RTL and testbench
===============================

Name: pred_ctx_seq

Overview:
- Per-PE context sequencer that drives the control side of the predicate register file (pred_reg9).
- Holds a small context memory of predicate-routing words, loaded through a config port.
- On start, steps through contexts 0..cfg_last once per CLK for cfg_iters iterations, presenting one registered control word per cycle.
- Forces safe control values whenever it is not running.

Parameters:
- CTX_DEPTH, 16, number of context words.
- ADDR_W, 4, context address width; CTX_DEPTH = 2**ADDR_W.
- ITER_W, 8, iteration counter width.
- SCRATCH, 63, predicate register index used as the harmless put_in target when idle.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- cfg_we  in  1  context write strobe.
- cfg_addr  in  ADDR_W  context write address.
- cfg_data  in  47  context word. Field layout, MSB to LSB: in_sel[8:0], put_in[5:0], put_out[5:0], wb[0], pred[5:0], pe2fu[3:0], send[5:0], out_sel[8:0].
- cfg_last  in  ADDR_W  index of the last context per iteration; sampled at start.
- cfg_iters  in  ITER_W  iteration count; sampled at start.
- start  in  1  one-cycle run request.
- stop  in  1  abort request.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on completion or abort.
- ctx_err  out  1  sticky illegal-in_sel flag.
- pc  out  ADDR_W  current context index.
- control_in_p  out  9  source select to pred_reg9.
- control_put_in_p  out  6  incoming-predicate write index.
- control_put_out_p  out  6  FU write-back index.
- write_back_p  out  1  FU write-back enable.
- control_pred  out  6  pred_out read index.
- control_pe2fu_p  out  4  pred_out source select.
- control_send_p  out  6  demux read index.
- control_out_p  out  9  output edge enables.

Behaviour:
- FSM states: IDLE, RUN, DONE. RST forces IDLE, pc=0, iter=0, busy=0, done=0, ctx_err=0, and the safe control set.
- Context memory contents are not reset.
- Safe control set:
  - control_in_p=0, control_put_in_p=SCRATCH, control_put_out_p=SCRATCH, write_back_p=0.
  - control_pred=0, control_pe2fu_p=4'b1111 (pred_out=0), control_send_p=0, control_out_p=0.
- cfg_we writes ctx[cfg_addr] only in IDLE. Writes in RUN or DONE are dropped.
- IDLE + start:
  - Latch last=cfg_last and iter=cfg_iters; pc=0; clear ctx_err.
  - If cfg_iters==0, go to DONE; otherwise go to RUN.
  - start in RUN or DONE is ignored.
- RUN, each cycle:
  - Control outputs register the fields of ctx[pc], so they change one cycle after pc. Outputs are posedge-registered and therefore stable at pred_reg9's negedge sampling.
  - If pc==last: pc wraps to 0 and iter decrements. If iter was 1, next state is DONE.
  - Otherwise pc increments.
  - pc never exceeds last. last=0 issues context 0 every cycle.
- in_sel check: legal values are 0, 9'h008, 9'h004, 9'h010. Any other value drives control_in_p=0 and sets ctx_err. All other fields still issue.
- stop in RUN: next state DONE, same priority as normal completion. The word for the current pc is not issued; safe set is driven next cycle.
- DONE: done=1 for exactly one cycle, safe control set, busy=0; then IDLE. pc is held for debug until the next start.
- RST asserted mid-RUN: safe set on the next edge with no done pulse.
- start and stop together in IDLE: start wins; stop is ignored outside RUN.

Test Plan:
- Load ctx0..ctx2 with in_sel=9'h008/9'h004/9'h010, put_in=1/2/3; cfg_last=2, cfg_iters=2, pulse start → control_put_in_p sequence 1,2,3,1,2,3 on consecutive cycles starting one cycle after busy rises; done pulses once; then put_in=63.
- cfg_iters=0 with start → no context issued, done high on the 2nd cycle after start, busy never set.
- ctx1 in_sel=9'h0FF → during that issue control_in_p=0, ctx_err=1, and it stays 1 until the next start.
- stop asserted on the 3rd RUN cycle with cfg_last=7, cfg_iters=5 → safe set next cycle, done=1 for one cycle, IDLE.
- cfg_we to ctx0 during RUN with data wb=1, then rerun → ctx0 unchanged (wb=0). RST mid-RUN → safe set and done=0.
- cfg_last=0, cfg_iters=3 → ctx0 issued 3 consecutive cycles, pc stays 0.

Source files
------------

// File: rtl/pred_ctx_seq.sv
// Per-PE context sequencer feeding the control side of pred_reg9.
// Steps a loaded context memory for a number of iterations, safe set otherwise.
module pred_ctx_seq #(
  parameter int CTX_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int ITER_W    = 8,
  parameter int SCRATCH   = 63
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [46:0]       cfg_data,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic [ITER_W-1:0] cfg_iters,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              ctx_err,
  output logic [ADDR_W-1:0] pc,
  output logic [8:0]        control_in_p,
  output logic [5:0]        control_put_in_p,
  output logic [5:0]        control_put_out_p,
  output logic              write_back_p,
  output logic [5:0]        control_pred,
  output logic [3:0]        control_pe2fu_p,
  output logic [5:0]        control_send_p,
  output logic [8:0]        control_out_p
);

  typedef struct packed {
    logic [8:0] in_sel;
    logic [5:0] put_in;
    logic [5:0] put_out;
    logic       wb;
    logic [5:0] pred;
    logic [3:0] pe2fu;
    logic [5:0] send;
    logic [8:0] out_sel;
  } ctx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam ctx_t SAFE = '{
    in_sel:  9'd0,
    put_in:  6'(SCRATCH),
    put_out: 6'(SCRATCH),
    wb:      1'b0,
    pred:    6'd0,
    pe2fu:   4'b1111,
    send:    6'd0,
    out_sel: 9'd0
  };

  ctx_t              ctx_mem [CTX_DEPTH];
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] last_q;
  logic [ITER_W-1:0] iter_q;
  logic              done_q;
  logic              err_q;
  ctx_t              ctl_q;
  ctx_t              word;
  ctx_t              issue;
  logic              legal;
  logic              wrap;

  assign word  = ctx_mem[pc_q];
  assign legal = word.in_sel inside {9'h000, 9'h004, 9'h008, 9'h010};
  assign wrap  = (pc_q == last_q);

  always_comb begin
    issue = word;
    if (!legal) issue.in_sel = 9'd0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start)
          state_d = (cfg_iters == '0) ? DONE : RUN;
      RUN:
        if (stop || (wrap && iter_q == ITER_W'(1)))
          state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Context memory is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (cfg_we && state_q == IDLE)
      ctx_mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ctl_q   <= SAFE;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      ctl_q   <= SAFE;
      if (state_q == IDLE && start) begin
        last_q <= cfg_last;
        iter_q <= cfg_iters;
        pc_q   <= '0;
        err_q  <= 1'b0;
      end
      // A stop cycle issues nothing; pc is held for debug.
      if (state_q == RUN && !stop) begin
        ctl_q <= issue;
        if (!legal) err_q <= 1'b1;
        if (wrap) begin
          pc_q   <= '0;
          iter_q <= iter_q - ITER_W'(1);
        end else begin
          pc_q <= pc_q + ADDR_W'(1);
        end
      end
    end
  end

  assign busy              = (state_q == RUN);
  assign done              = done_q;
  assign ctx_err           = err_q;
  assign pc                = pc_q;
  assign control_in_p      = ctl_q.in_sel;
  assign control_put_in_p  = ctl_q.put_in;
  assign control_put_out_p = ctl_q.put_out;
  assign write_back_p      = ctl_q.wb;
  assign control_pred      = ctl_q.pred;
  assign control_pe2fu_p   = ctl_q.pe2fu;
  assign control_send_p    = ctl_q.send;
  assign control_out_p     = ctl_q.out_sel;

endmodule

// File: tb/tb_pred_ctx_seq.sv
// Directed bench for pred_ctx_seq.
// Expected values are hand-derived from the intended cycle behaviour.
module tb_pred_ctx_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [46:0] cfg_data;
  logic [3:0]  cfg_last;
  logic [7:0]  cfg_iters;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic        ctx_err;
  logic [3:0]  pc;
  logic [8:0]  control_in_p;
  logic [5:0]  control_put_in_p;
  logic [5:0]  control_put_out_p;
  logic        write_back_p;
  logic [5:0]  control_pred;
  logic [3:0]  control_pe2fu_p;
  logic [5:0]  control_send_p;
  logic [8:0]  control_out_p;

  int n_cmp = 0;
  int n_err = 0;

  pred_ctx_seq dut (
    .CLK(CLK),
    .RST(RST),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_last(cfg_last),
    .cfg_iters(cfg_iters),
    .start(start),
    .stop(stop),
    .busy(busy),
    .done(done),
    .ctx_err(ctx_err),
    .pc(pc),
    .control_in_p(control_in_p),
    .control_put_in_p(control_put_in_p),
    .control_put_out_p(control_put_out_p),
    .write_back_p(write_back_p),
    .control_pred(control_pred),
    .control_pe2fu_p(control_pe2fu_p),
    .control_send_p(control_send_p),
    .control_out_p(control_out_p)
  );

  always #5 CLK = ~CLK;

  function automatic logic [46:0] mk(
    input logic [8:0] in_sel, input logic [5:0] put_in,
    input logic [5:0] put_out, input logic wb,
    input logic [5:0] pred, input logic [3:0] pe2fu,
    input logic [5:0] send, input logic [8:0] out_sel);
    return {in_sel, put_in, put_out, wb, pred, pe2fu, send, out_sel};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [46:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic safe_chk(input string tag);
    chk({tag, "_in"}, control_in_p, 9'd0);
    chk({tag, "_putin"}, control_put_in_p, 6'd63);
    chk({tag, "_putout"}, control_put_out_p, 6'd63);
    chk({tag, "_wb"}, write_back_p, 1'b0);
    chk({tag, "_pe2fu"}, control_pe2fu_p, 4'hF);
    chk({tag, "_out"}, control_out_p, 9'd0);
  endtask

  initial begin
    RST = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_last = '0;
    cfg_iters = '0;
    start = 1'b0;
    stop = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", ctx_err, 1'b0);
    chk("rst_pc", pc, 4'd0);
    safe_chk("rst");

    // two iterations over three contexts
    wr(4'd0, mk(9'h008, 6'd1, 6'd5, 1'b0, 6'd7, 4'h2, 6'd9, 9'h1AA));
    wr(4'd1, mk(9'h004, 6'd2, 6'd6, 1'b0, 6'd8, 4'h3, 6'd10, 9'h055));
    wr(4'd2, mk(9'h010, 6'd3, 6'd7, 1'b1, 6'd9, 4'h4, 6'd11, 9'h0F0));
    cfg_last = 4'd2;
    cfg_iters = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_pre", control_put_in_p, 6'd63);
    tick();
    chk("t1_put0", control_put_in_p, 6'd1);
    chk("t1_in0", control_in_p, 9'h008);
    chk("t1_out0", control_out_p, 9'h1AA);
    chk("t1_pe2fu0", control_pe2fu_p, 4'h2);
    chk("t1_pred0", control_pred, 6'd7);
    chk("t1_send0", control_send_p, 6'd9);
    tick();
    chk("t1_put1", control_put_in_p, 6'd2);
    chk("t1_in1", control_in_p, 9'h004);
    tick();
    chk("t1_put2", control_put_in_p, 6'd3);
    chk("t1_wb2", write_back_p, 1'b1);
    chk("t1_pc2", pc, 4'd0);
    tick();
    chk("t1_put3", control_put_in_p, 6'd1);
    tick();
    chk("t1_put4", control_put_in_p, 6'd2);
    chk("t1_done4", done, 1'b0);
    tick();
    chk("t1_put5", control_put_in_p, 6'd3);
    chk("t1_busy5", busy, 1'b0);
    chk("t1_done5", done, 1'b0);
    tick();
    chk("t1_done", done, 1'b1);
    safe_chk("t1_end");
    tick();
    chk("t1_done_off", done, 1'b0);

    // zero iterations
    cfg_iters = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_busy0", busy, 1'b0);
    chk("t2_done0", done, 1'b0);
    chk("t2_put0", control_put_in_p, 6'd63);
    tick();
    chk("t2_busy1", busy, 1'b0);
    chk("t2_done1", done, 1'b1);
    chk("t2_put1", control_put_in_p, 6'd63);
    tick();
    chk("t2_done2", done, 1'b0);

    // illegal in_sel on ctx1
    wr(4'd1, mk(9'h0FF, 6'd2, 6'd6, 1'b0, 6'd8, 4'h3, 6'd10, 9'h055));
    cfg_iters = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t3_in0", control_in_p, 9'h008);
    chk("t3_err0", ctx_err, 1'b0);
    tick();
    chk("t3_in1", control_in_p, 9'h000);
    chk("t3_put1", control_put_in_p, 6'd2);
    chk("t3_out1", control_out_p, 9'h055);
    chk("t3_err1", ctx_err, 1'b1);
    tick();
    chk("t3_in2", control_in_p, 9'h010);
    chk("t3_err2", ctx_err, 1'b1);
    tick();
    chk("t3_done", done, 1'b1);
    chk("t3_err3", ctx_err, 1'b1);
    tick();
    chk("t3_err4", ctx_err, 1'b1);

    // stop on third RUN cycle
    cfg_last = 4'd7;
    cfg_iters = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_clr", ctx_err, 1'b0);
    chk("t4_busy", busy, 1'b1);
    tick();
    chk("t4_put0", control_put_in_p, 6'd1);
    tick();
    chk("t4_put1", control_put_in_p, 6'd2);
    chk("t4_pc", pc, 4'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_busy_off", busy, 1'b0);
    chk("t4_done0", done, 1'b0);
    chk("t4_pc_hold", pc, 4'd2);
    safe_chk("t4_stop");
    tick();
    chk("t4_done1", done, 1'b1);
    safe_chk("t4_done");
    tick();
    chk("t4_done2", done, 1'b0);
    chk("t4_busy2", busy, 1'b0);

    // write during RUN dropped, then reset mid-RUN
    cfg_last = 4'd2;
    cfg_iters = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = mk(9'h004, 6'd9, 6'd9, 1'b1, 6'd1, 4'h1, 6'd1, 9'h001);
    tick();
    cfg_we = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_done", done, 1'b0);
    chk("t5_busy", busy, 1'b0);
    safe_chk("t5_rst");
    tick();
    chk("t5_done2", done, 1'b0);

    // last=0, three iterations; start+stop in IDLE
    cfg_last = 4'd0;
    cfg_iters = 8'd3;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t6_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_put", control_put_in_p, 6'd1);
      chk("t6_wb", write_back_p, 1'b0);
      chk("t6_pc", pc, 4'd0);
    end
    chk("t6_busy_off", busy, 1'b0);
    tick();
    chk("t6_done", done, 1'b1);
    chk("t6_put_end", control_put_in_p, 6'd63);
    tick();
    chk("t6_done_off", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
